// File: rtl/sig_pkg.sv
// Shared constants and helpers for the moving-window integrator.
// Width/window helpers keep derived sizes in one place.
package sig_pkg;

  localparam logic MODE_SUM  = 1'b0;
  localparam logic MODE_MEAN = 1'b1;

  function automatic int out_w(
    input int data_w,
    input int win_log2
  );
    return data_w + win_log2;
  endfunction

  function automatic int win_len(
    input int win_log2
  );
    return 1 << win_log2;
  endfunction

  function automatic bit params_ok(
    input int data_w,
    input int win_log2
  );
    return (data_w >= 4) && (data_w <= 16) &&
           (win_log2 >= 1) && (win_log2 <= 6);
  endfunction

endpackage

// File: rtl/sig_win_buf.sv
// Circular sample history: the slot under the write pointer is
// read as the oldest sample, then overwritten by the new one.
module sig_win_buf
  import sig_pkg::*;
#(
  parameter int DATA_W   = 9,
  parameter int WIN_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int WIN = win_len(WIN_LOG2);

  logic [DATA_W-1:0]   mem_q [WIN];
  logic [WIN_LOG2-1:0] ptr_q;
  logic [WIN_LOG2-1:0] ptr_d;

  assign rdata_o = mem_q[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (we_i) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      for (int i = 0; i < WIN; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      if (clr_i) begin
        for (int i = 0; i < WIN; i++) begin
          mem_q[i] <= '0;
        end
      end else if (we_i) begin
        mem_q[ptr_q] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/sig_inte_win.sv
// Streaming moving-window integrator: running sum of the last
// 2^WIN_LOG2 samples, optional mean, warm-up flag and clear.
module sig_inte_win
  import sig_pkg::*;
#(
  parameter int DATA_W   = 9,
  parameter int WIN_LOG2 = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  input  logic [DATA_W-1:0]                     in_data,
  input  logic                                  mode,
  input  logic                                  clear,
  output logic                                  out_valid,
  output logic [out_w(DATA_W, WIN_LOG2)-1:0]    out_data,
  output logic                                  out_full
);

  localparam int OUT_W = out_w(DATA_W, WIN_LOG2);
  localparam logic [WIN_LOG2:0] FILL_MAX =
    {1'b1, {WIN_LOG2{1'b0}}};

  if (!params_ok(DATA_W, WIN_LOG2)) begin : g_bad_params
    $error("sig_inte_win: DATA_W or WIN_LOG2 out of range");
  end

  logic                    accept;
  logic [DATA_W-1:0]       oldest;
  logic signed [DATA_W:0]  diff;

  logic                    v1_q;
  logic                    v1_d;
  logic signed [DATA_W:0]  delta_q;
  logic signed [DATA_W:0]  delta_d;
  logic [WIN_LOG2:0]       fill_q;
  logic [WIN_LOG2:0]       fill_d;
  logic signed [OUT_W-1:0] acc_q;
  logic signed [OUT_W-1:0] acc_d;
  logic                    ov_q;
  logic                    ov_d;
  logic [OUT_W-1:0]        od_q;
  logic [OUT_W-1:0]        od_d;
  logic                    of_q;
  logic                    of_d;

  logic signed [OUT_W-1:0] dext;
  logic signed [OUT_W-1:0] sum;
  logic signed [OUT_W-1:0] mean;
  logic [OUT_W-1:0]        out_sel;

  assign accept = in_valid && !clear;

  sig_win_buf #(
    .DATA_W   (DATA_W),
    .WIN_LOG2 (WIN_LOG2)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clear),
    .we_i    (accept),
    .wdata_i (in_data),
    .rdata_o (oldest)
  );

  // Empty slots read as zero, so warm-up sums stay exact.
  assign diff = $signed({in_data[DATA_W-1], in_data}) -
                $signed({oldest[DATA_W-1], oldest});

  assign dext = OUT_W'(delta_q);
  assign sum  = acc_q + dext;
  assign mean = sum >>> WIN_LOG2;

  always_comb begin
    out_sel = sum;
    unique case (mode)
      MODE_SUM:  out_sel = sum;
      MODE_MEAN: out_sel = mean;
    endcase
  end

  always_comb begin
    v1_d    = accept;
    delta_d = accept ? diff : delta_q;
    fill_d  = fill_q;
    if (clear) begin
      fill_d = '0;
    end else if (accept && (fill_q != FILL_MAX)) begin
      fill_d = fill_q + 1'b1;
    end
  end

  always_comb begin
    acc_d = acc_q;
    ov_d  = 1'b0;
    od_d  = od_q;
    of_d  = of_q;
    if (clear) begin
      acc_d = '0;
      of_d  = 1'b0;
    end else if (v1_q) begin
      acc_d = sum;
      ov_d  = 1'b1;
      od_d  = out_sel;
      if (fill_q == FILL_MAX) begin
        of_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      delta_q <= '0;
      fill_q  <= '0;
      acc_q   <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      of_q    <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      delta_q <= delta_d;
      fill_q  <= fill_d;
      acc_q   <= acc_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      of_q    <= of_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_full  = of_q;

endmodule

// File: tb/tb_sig_inte_win.sv
// Bench for sig_inte_win: three parameter sets against a
// last-WIN-samples window model, plus directed literal cases.
module tb_sig_inte_win;

  localparam int WL [3] = '{4, 6, 1};

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  iv    = '0;
  logic [2:0]  md    = '0;
  logic [2:0]  cl    = '0;
  logic [8:0]  din0  = '0;
  logic [11:0] din1  = '0;
  logic [11:0] din2  = '0;
  logic [2:0]  ov;
  logic [2:0]  of;
  logic [12:0] od0;
  logic [17:0] od1;
  logic [12:0] od2;

  always #5 clk = ~clk;

  sig_inte_win #(.DATA_W(9), .WIN_LOG2(4)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_data(din0),
    .mode(md[0]), .clear(cl[0]), .out_valid(ov[0]),
    .out_data(od0), .out_full(of[0]));

  sig_inte_win #(.DATA_W(12), .WIN_LOG2(6)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_data(din1),
    .mode(md[1]), .clear(cl[1]), .out_valid(ov[1]),
    .out_data(od1), .out_full(of[1]));

  sig_inte_win #(.DATA_W(12), .WIN_LOG2(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_data(din2),
    .mode(md[2]), .clear(cl[2]), .out_valid(ov[2]),
    .out_data(od2), .out_full(of[2]));

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint din_s(input int k);
    case (k)
      0:       return longint'($signed(din0));
      1:       return longint'($signed(din1));
      default: return longint'($signed(din2));
    endcase
  endfunction

  function automatic longint dout_s(input int k);
    case (k)
      0:       return longint'($signed(od0));
      1:       return longint'($signed(od1));
      default: return longint'($signed(od2));
    endcase
  endfunction

  // Floor division, independent of any shifting.
  function automatic longint fdiv(input longint s, input longint w);
    longint q;
    q = s / w;
    if ((s % w != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  // Model: window of the last WIN accepted samples since reset/clear.
  longint wq [3][$];
  longint cnt   [3];
  longint psum  [3];
  longint e_d   [3];
  bit     pend  [3];
  bit     pfull [3];
  bit     e_v   [3];
  bit     e_f   [3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      cnt[k] = 0; psum[k] = 0; e_d[k] = 0;
      pend[k] = 0; pfull[k] = 0; e_v[k] = 0; e_f[k] = 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin : mdl
    longint s;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        wq[k].delete();
        cnt[k] = 0; pend[k] = 0;
        e_v[k] = 0; e_d[k] = 0; e_f[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (cl[k]) begin
          e_v[k] = 0;
          e_f[k] = 0;
        end else begin
          e_v[k] = pend[k];
          if (pend[k]) begin
            e_d[k] = md[k] ? fdiv(psum[k], longint'(1) << WL[k])
                           : psum[k];
            e_f[k] = pfull[k];
          end
        end
        if (cl[k]) begin
          wq[k].delete();
          cnt[k]  = 0;
          pend[k] = 0;
        end else if (iv[k]) begin
          wq[k].push_back(din_s(k));
          if (wq[k].size() > (1 << WL[k])) void'(wq[k].pop_front());
          cnt[k]++;
          s = 0;
          for (int j = 0; j < wq[k].size(); j++) s += wq[k][j];
          psum[k]  = s;
          pfull[k] = (cnt[k] >= (1 << WL[k]));
          pend[k]  = 1;
        end else begin
          pend[k] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("valid%0d", k), longint'(ov[k]), longint'(e_v[k]));
      chk($sformatf("data%0d", k), dout_s(k), e_d[k]);
      chk($sformatf("full%0d", k), longint'(of[k]), longint'(e_f[k]));
    end
  end

  longint got0 [$];
  bit     gf0  [$];

  always @(negedge clk) begin
    if (ov[0]) begin
      got0.push_back(longint'($signed(od0)));
      gf0.push_back(of[0]);
    end
  end

  task automatic drv0(input bit v, input int d, input bit m,
                      input bit c);
    @(negedge clk);
    iv[0] = v;
    din0  = d[8:0];
    md[0] = m;
    cl[0] = c;
  endtask

  task automatic idle0(input int n);
    repeat (n) drv0(1'b0, 0, md[0], 1'b0);
  endtask

  task automatic clr0();
    drv0(1'b0, 0, md[0], 1'b1);
    idle0(3);
    got0.delete();
    gf0.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", longint'(ov[0]), 0);
    chk("rst_data", longint'(od0), 0);
    chk("rst_full", longint'(of[0]), 0);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 17; i++) drv0(1'b1, 10, 1'b0, 1'b0);
    idle0(4);
    chk("ramp_count", got0.size(), 17);
    chk("ramp_first", got0[0], 10);
    chk("ramp_8", got0[7], 80);
    chk("ramp_16", got0[15], 160);
    chk("ramp_17", got0[16], 160);
    chk("full_at_15", longint'(gf0[14]), 0);
    chk("full_at_16", longint'(gf0[15]), 1);

    clr0();
    for (int i = 0; i < 16; i++) drv0(1'b1, 255, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) drv0(1'b1, -256, 1'b0, 1'b0);
    idle0(4);
    chk("ext_count", got0.size(), 32);
    chk("ext_pos", got0[15], 4080);
    chk("ext_mix", got0[23], 255 * 8 - 256 * 8);
    chk("ext_neg", got0[31], -4096);

    clr0();
    for (int i = 1; i <= 20; i++) drv0(1'b1, i, 1'b1, 1'b0);
    idle0(4);
    chk("mean_1", got0[0], 0);
    chk("mean_16", got0[15], 8);
    chk("mean_20", got0[19], 12);

    clr0();
    drv0(1'b1, -1, 1'b1, 1'b0);
    idle0(3);
    chk("mean_neg1", got0[0], -1);

    drv0(1'b0, 0, 1'b0, 1'b0);
    clr0();
    for (int i = 1; i <= 20; i++) begin
      drv0(1'b1, i, 1'b0, 1'b0);
      idle0(2);
    end
    idle0(3);
    chk("gap_count", got0.size(), 20);
    chk("gap_sum20", got0[19], 200);

    clr0();
    for (int i = 0; i < 20; i++)
      drv0(1'b1, int'($urandom_range(0, 511)), 1'b0, 1'b0);
    drv0(1'b1, 99, 1'b0, 1'b1);
    drv0(1'b0, 0, 1'b0, 1'b0);
    chk("clr_squash", longint'(ov[0]), 0);
    chk("clr_full", longint'(of[0]), 0);
    drv0(1'b1, 37, 1'b0, 1'b0);
    idle0(3);
    chk("clr_count", got0.size(), 20);
    chk("clr_next", got0[got0.size() - 1], 37);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        iv[k] = 1'($urandom_range(0, 1));
        md[k] = 1'($urandom_range(0, 1));
        cl[k] = ($urandom_range(0, 399) == 0);
      end
      din0 = 9'($urandom);
      din1 = 12'($urandom);
      din2 = 12'($urandom);
      if (cyc == 1500) begin
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid0", longint'(ov[0]), 0);
        chk("arst_data0", longint'(od0), 0);
        chk("arst_full0", longint'(of[0]), 0);
        chk("arst_valid1", longint'(ov[1]), 0);
        chk("arst_data1", longint'(od1), 0);
        chk("arst_full1", longint'(of[1]), 0);
        chk("arst_valid2", longint'(ov[2]), 0);
        chk("arst_data2", longint'(od2), 0);
        chk("arst_full2", longint'(of[2]), 0);
      end
      if (cyc == 1502) #2 rst_n = 1'b1;
    end

    @(negedge clk);
    iv = '0;
    cl = '0;
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/sig_inte_win.md
# sig_inte_win

Parametrised streaming moving-window integrator for the ECG front end. It replaces the fixed 16-tap adder-tree integrator with a recursive running sum: add the newest sample, subtract the oldest. Window length and data width are set by parameters, and input/output valid strobes let it run from the decimated sample clock-enable. It also provides mean mode, a warm-up flag and a synchronous clear, and sits between the band-pass/derivative stages and the QRS feature extractor.

## Interface
- DATA_W, 9, signed input sample width (4..16)
- WIN_LOG2, 4, window length WIN = 2^WIN_LOG2 samples (1..6)
- OUT_W, DATA_W+WIN_LOG2 (derived, not overridable), output width
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  in_data carries a new sample this cycle
- in_data  in  DATA_W  signed sample
- mode  in  1  0 = window sum, 1 = window mean (sum >>> WIN_LOG2)
- clear  in  1  synchronous flush of window history
- out_valid  out  1  one-cycle strobe, out_data updated
- out_data  out  OUT_W  signed sum or sign-extended mean
- out_full  out  1  window holds WIN real samples since reset/clear

## Operation
- State:
  - history buffer of WIN entries of DATA_W bits
  - write pointer wr_ptr, WIN_LOG2 bits, wrapping WIN-1 -> 0
  - accumulator acc, OUT_W bits
  - fill counter fill, 0..WIN, saturating
- Stage 1, on in_valid && !clear:
  - oldest = buf[wr_ptr]; buf[wr_ptr] <= in_data; wr_ptr++ (mod WIN)
  - delta <= in_data - oldest, DATA_W+1 bits signed; v1 <= 1
  - fill++ unless fill == WIN
- Stage 2, on v1:
  - acc <= acc + sign_ext(delta)
  - out_data <= mode ? sign_ext((acc+delta) >>> WIN_LOG2) : acc+delta; out_valid <= 1
  - out_data uses the new acc value, not the previous one
- Arithmetic:
  - acc never overflows: |sum| <= WIN*2^(DATA_W-1) fits OUT_W.
  - The mean uses an arithmetic shift, so it rounds toward -inf (e.g. sum -1 -> mean -1).
- Warm-up: the empty buffer reads as 0, so partial sums during warm-up are exact sums of the samples seen so far.
  - out_full goes high together with the out_valid of the WIN-th accepted sample.
  - It stays high until clear or reset.
- clear:
  - Zeroes buf, wr_ptr, acc, fill, v1 and out_full in one cycle.
  - Clear takes priority: an in_valid in the same cycle is dropped.
  - A stage-2 result in flight is squashed, so out_valid is 0 on the next cycle.
  - out_data holds its last value.
- mode is sampled in stage 2 and may change at any time without corrupting acc.
- No backpressure. Back-to-back in_valid every cycle is supported at full rate.

## Timing
- Reset (rst_n low, asynchronous): buf=0, wr_ptr=0, acc=0, fill=0, v1=0, out_valid=0, out_data=0, out_full=0.
- Latency: in_valid at cycle N -> out_valid at N+2. Throughput 1 sample/cycle.
- out_valid is a single-cycle strobe per accepted sample. Output count always equals input count, minus samples dropped or squashed by clear.
- Deasserting rst_n mid-stream discards the pipeline. The first in_valid after reset release starts a fresh window.

## Structure
- Shared package sig_pkg:
  - function out_w(data_w, win_log2)
  - MODE_SUM=0, MODE_MEAN=1
  - parameter range checks
- One sub-module, sig_win_buf: a WIN-deep circular history with a read-old-then-write port, wr_ptr, and clear.
- The top level holds delta/acc, the output register, fill and out_full.

## Test plan
- Reset, then 16 consecutive samples of +10, mode=0, defaults: out_data ramps 10, 20 … 160. out_full rises with the 16th out_valid. A 17th +10 gives 160.
- Extremes, DATA_W=9: 16× +255 -> 4080; then 16× -256 -> final -4096. No wrap at any step.
- Mean mode on the running sequence 1..20: after sample 20 the sum is 5+…+20 = 200 and the mean is 12. A window sum of -1 gives mean -1.
- Gapped in_valid (one sample every 3 cycles): every out_valid arrives exactly 2 cycles after its in_valid, and the sums match the gap-free run.
- clear asserted in the same cycle as in_valid after 20 samples: that sample is dropped and the pending out_valid is squashed. out_full=0, and the next sample x gives out_data = x.
- Parameter sweep (DATA_W=12, WIN_LOG2=6 and WIN_LOG2=1): random stimulus checked against a reference model of the last-WIN sum and mean. Mid-stream async reset returns all outputs to 0 within the same cycle.
